aes_decode_block: RTL

- Iterative AES decipher datapath; the inverse of the existing encipher round engine.
- Consumes round keys in reverse order, Nr down to 0, from the shared key memory.
- Drives an external combinational inverse S-box with one 32-bit word per cycle.
- Sits beside the encoder in the AES core; the core muxes key-memory and S-box ports by mode.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_decode_block_if.sv | 22 ++
 rtl/aes_inv_mixcolumns.sv | 23 ++
 rtl/aes_decode_block.sv | 135 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES shared constants: key-length codes, round counts, control/update encodings,
// GF(2^8) multiply helpers and the InvShiftRows permutation.
package aes_pkg;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam logic [3:0] AES_128_ROUNDS = 4'ha;
   localparam logic [3:0] AES_256_ROUNDS = 4'he;

   localparam logic [1:0] CTRL_IDLE = 2'd0;
   localparam logic [1:0] CTRL_INIT = 2'd1;
   localparam logic [1:0] CTRL_SBOX = 2'd2;
   localparam logic [1:0] CTRL_MAIN = 2'd3;

   localparam logic [2:0] UPD_NO    = 3'd0;
   localparam logic [2:0] UPD_INIT  = 3'd1;
   localparam logic [2:0] UPD_SBOX  = 3'd2;
   localparam logic [2:0] UPD_MAIN  = 3'd3;
   localparam logic [2:0] UPD_FINAL = 3'd4;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   function automatic logic [7:0] gm9(input logic [7:0] b);
      return gm2(gm2(gm2(b))) ^ b;
   endfunction

   function automatic logic [7:0] gm11(input logic [7:0] b);
      return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
   endfunction

   function automatic logic [7:0] gm13(input logic [7:0] b);
      return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
   endfunction

   function automatic logic [7:0] gm14(input logic [7:0] b);
      return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
   endfunction

   // Row j of the output is row j of the input rotated right by j words.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = d;
      return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
              w1[31:24], w0[23:16], w3[15:8], w2[7:0],
              w2[31:24], w1[23:16], w0[15:8], w3[7:0],
              w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
   endfunction

endpackage

// File: rtl/aes_decode_block_if.sv
// Control, key-memory and inverse-S-box signal group of the AES decipher datapath.
interface aes_decode_block_if;
   logic         next;
   logic         keylen;
   logic [3:0]   round_no;
   logic [127:0] round_key;
   logic [31:0]  sbox_word;
   logic [31:0]  new_sbox_word;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, round_key, new_sbox_word, block,
      input  round_no, sbox_word, new_block, ready
   );

   modport slave (
      input  next, keylen, round_key, new_sbox_word, block,
      output round_no, sbox_word, new_block, ready
   );
endinterface

// File: rtl/aes_inv_mixcolumns.sv
// Combinational AES InvMixColumns over all four 32-bit columns of a 128-bit state.
module aes_inv_mixcolumns
   import aes_pkg::*;
(
   input  logic [127:0] data,
   output logic [127:0] result
);

   function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = w;
      return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
              gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
              gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
              gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
   endfunction

   always_comb begin
      result = {inv_mix_word(data[127:96]), inv_mix_word(data[95:64]),
                inv_mix_word(data[63:32]),  inv_mix_word(data[31:0])};
   end

endmodule

// File: rtl/aes_decode_block.sv
// Iterative AES decipher datapath: one InvSubBytes word per cycle, round keys Nr..0.
// Optional AES_DEC_DONE_PULSE_EN adds a one-cycle `done` pulse on completion.
module aes_decode_block
   import aes_pkg::*;
(
   input  logic clk,
   input  logic reset,
   aes_decode_block_if.slave bus
`ifdef AES_DEC_DONE_PULSE_EN
   ,
   output logic done
`endif
);

   logic [1:0]   ctrl_reg;
   logic [3:0]   round_ctr_reg;
   logic [1:0]   sword_ctr_reg;
   logic         ready_reg;
   logic         keylen_reg;
   logic [127:0] block_reg;
   logic [2:0]   upd_type;
   logic [127:0] add_key;
   logic [127:0] imc_out;
   logic [31:0]  sword;

   function automatic logic [3:0] num_rounds(input logic kl);
      return (kl == AES_256_BIT_KEY) ? AES_256_ROUNDS : AES_128_ROUNDS;
   endfunction

   assign add_key = block_reg ^ bus.round_key;

   aes_inv_mixcolumns u_inv_mixcolumns (
      .data   (add_key),
      .result (imc_out)
   );

   always_comb begin
      sword = block_reg[127:96];
      case (sword_ctr_reg)
         2'd0:    sword = block_reg[127:96];
         2'd1:    sword = block_reg[95:64];
         2'd2:    sword = block_reg[63:32];
         default: sword = block_reg[31:0];
      endcase
   end

   always_comb begin
      upd_type = UPD_NO;
      case (ctrl_reg)
         CTRL_INIT: upd_type = UPD_INIT;
         CTRL_SBOX: upd_type = UPD_SBOX;
         CTRL_MAIN: upd_type = (round_ctr_reg == 4'd0) ? UPD_FINAL : UPD_MAIN;
         default:   upd_type = UPD_NO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         block_reg <= '0;
      end else begin
         case (upd_type)
            UPD_INIT:  block_reg <= inv_shift_rows(bus.block ^ bus.round_key);
            UPD_SBOX: begin
               case (sword_ctr_reg)
                  2'd0:    block_reg[127:96] <= bus.new_sbox_word;
                  2'd1:    block_reg[95:64]  <= bus.new_sbox_word;
                  2'd2:    block_reg[63:32]  <= bus.new_sbox_word;
                  default: block_reg[31:0]   <= bus.new_sbox_word;
               endcase
            end
            UPD_MAIN:  block_reg <= inv_shift_rows(imc_out);
            UPD_FINAL: block_reg <= add_key;
            default:   block_reg <= block_reg;
         endcase
      end
   end

   // round_ctr is pre-decremented on INIT/MAIN so the key index the SBOX cycles
   // present is already the one the following MAIN consumes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_reg      <= CTRL_IDLE;
         round_ctr_reg <= '0;
         sword_ctr_reg <= '0;
         ready_reg     <= 1'b1;
         keylen_reg    <= AES_128_BIT_KEY;
      end else begin
         case (ctrl_reg)
            CTRL_IDLE: begin
               if (bus.next) begin
                  keylen_reg    <= bus.keylen;
                  round_ctr_reg <= num_rounds(bus.keylen);
                  ready_reg     <= 1'b0;
                  ctrl_reg      <= CTRL_INIT;
               end
            end
            CTRL_INIT: begin
               round_ctr_reg <= num_rounds(keylen_reg) - 4'd1;
               sword_ctr_reg <= '0;
               ctrl_reg      <= CTRL_SBOX;
            end
            CTRL_SBOX: begin
               sword_ctr_reg <= sword_ctr_reg + 2'd1;
               if (sword_ctr_reg == 2'd3)
                  ctrl_reg <= CTRL_MAIN;
            end
            CTRL_MAIN: begin
               if (round_ctr_reg != 4'd0) begin
                  round_ctr_reg <= round_ctr_reg - 4'd1;
                  ctrl_reg      <= CTRL_SBOX;
               end else begin
                  ready_reg <= 1'b1;
                  ctrl_reg  <= CTRL_IDLE;
               end
            end
            default: ctrl_reg <= CTRL_IDLE;
         endcase
      end
   end

`ifdef AES_DEC_DONE_PULSE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         done <= 1'b0;
      else
         done <= (upd_type == UPD_FINAL);
   end
`endif

   assign bus.round_no  = round_ctr_reg;
   assign bus.sbox_word = (ctrl_reg == CTRL_SBOX) ? sword : '0;
   assign bus.new_block = block_reg;
   assign bus.ready     = ready_reg;

endmodule
